// File: rtl/nibble_ram.sv
// rtl/nibble_ram.sv - 4096x4 single-port RAM, shared tristate bus, post-reset clear; optional RAM_PARITY_EN adds even parity and parity_err
module nibble_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic              rd_drive;
  logic [DATA_W-1:0] rd_word;

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
`endif

  // Clear sequencer: walk every address once after reset, then drop busy for good
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == {ADDR_W{1'b1}}) begin
        busy <= 1'b0;
      end
    end
  end

  // Single write port shared by the clear sequence and bus writes; bus writes lose while busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clr_ptr] <= '0;
`ifdef RAM_PARITY_EN
        par_mem[clr_ptr] <= 1'b0;
`endif
      end else if (cs && we) begin
        mem[address] <= data;
`ifdef RAM_PARITY_EN
        par_mem[address] <= ^data;
`endif
      end
    end
  end

  // Combinational read path; the array is hidden behind zeros until the clear completes
  assign rd_drive = cs && !we && !rst;
  assign rd_word  = busy ? '0 : mem[address];
  assign data     = rd_drive ? rd_word : {DATA_W{1'bz}};

`ifdef RAM_PARITY_EN
  // Stored parity is checked against the stored data only on a live read
  assign parity_err = cs && !we && !busy && !rst && (par_mem[address] != ^mem[address]);
`endif

endmodule

// File: tb/tb_nibble_ram.sv
// tb/tb_nibble_ram.sv - directed scoreboard bench for nibble_ram (bus pulled up so a released bus reads 4'b1111)
module tb_nibble_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [11:0] address;
  logic        busy;
  logic        tb_en;
  logic [3:0]  tb_data;
  tri1  [3:0]  data;
`ifdef RAM_PARITY_EN
  logic        parity_err;
`endif

  assign data = tb_en ? tb_data : 4'bzzzz;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  nibble_ram #(.ADDR_W(12), .DATA_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .data       (data),
`ifdef RAM_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare_bus();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, {28'd0, data}, {28'd0, e.val});
    end
  endtask

  task automatic read_at(input string tag, input logic [11:0] a, input logic [3:0] v);
    @(negedge clk);
    address = a;
    cs      = 1'b1;
    we      = 1'b0;
    tb_en   = 1'b0;
    expect_word(tag, v);
    #1;
    compare_bus();
  endtask

  task automatic write_at(input logic [11:0] a, input logic [3:0] v, input logic c);
    @(negedge clk);
    address = a;
    cs      = c;
    we      = 1'b1;
    tb_data = v;
    tb_en   = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    tb_en = 1'b0;
    cs    = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nz;

    rst     = 1'b1;
    cs      = 1'b0;
    we      = 1'b0;
    address = 12'h000;
    tb_en   = 1'b0;
    tb_data = 4'h0;

    // reset state
    #1;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_cs0_bus", {28'd0, data}, 32'hF);
    cs = 1'b1;
    #1;
    check("reset_read_bus", {28'd0, data}, 32'hF);

    // release reset, read during clear, count clear length
    @(negedge clk);
    rst = 1'b0;
    cs  = 1'b1;
    we  = 1'b0;
    address = 12'h000;
    #1;
    check("busy_after_release", {31'd0, busy}, 32'd1);
    check("busy_read_zero", {28'd0, data}, 32'h0);
    n  = 0;
    nz = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy && data !== 4'b0000) nz++;
    end while (busy && n < 5000);
    check("clear_cycles", n, 32'd4096);
    check("busy_read_nonzero_count", nz, 32'd0);
    check("busy_after_clear", {31'd0, busy}, 32'd0);

    read_at("clr_000", 12'h000, 4'b0000);
    read_at("clr_001", 12'h001, 4'b0000);
    read_at("clr_002", 12'h002, 4'b0000);
    read_at("clr_fff", 12'hFFF, 4'b0000);

    // write / readback
    write_at(12'h000, 4'b0011, 1'b1);
    write_at(12'h001, 4'b1100, 1'b1);
    write_at(12'h002, 4'b0110, 1'b1);
    read_at("rd_000", 12'h000, 4'b0011);
    read_at("rd_001", 12'h001, 4'b1100);
    read_at("rd_002", 12'h002, 4'b0110);

    // combinational address follow, no clock edge in between
    @(negedge clk);
    cs = 1'b1;
    we = 1'b0;
    address = 12'h002;
    expect_word("follow_002", 4'b0110);
    #1;
    compare_bus();
    address = 12'h001;
    expect_word("follow_001", 4'b1100);
    #1;
    compare_bus();

    // tristate: bus released reads as the pull-up value
    @(negedge clk);
    address = 12'h000;
    cs = 1'b0;
    we = 1'b0;
    expect_word("tri_cs0_we0", 4'b1111);
    #1;
    compare_bus();
    we = 1'b1;
    expect_word("tri_cs0_we1", 4'b1111);
    #1;
    compare_bus();
    cs = 1'b1;
    expect_word("tri_cs1_we1", 4'b1111);
    #1;
    compare_bus();
    we = 1'b0;
    expect_word("tri_back_to_read", 4'b0011);
    #1;
    compare_bus();

    write_at(12'h000, 4'b1001, 1'b0);
    read_at("cs0_write_ignored", 12'h000, 4'b0011);

    // boundary / overwrite
    write_at(12'hFFF, 4'b1010, 1'b1);
    read_at("fff_first", 12'hFFF, 4'b1010);
    write_at(12'hFFF, 4'b0101, 1'b1);
    read_at("fff_overwrite", 12'hFFF, 4'b0101);
    read_at("000_untouched", 12'h000, 4'b0011);

`ifdef RAM_PARITY_EN
    read_at("par_rd_001", 12'h001, 4'b1100);
    check("par_ok_001", {31'd0, parity_err}, 32'd0);
    read_at("par_rd_002", 12'h002, 4'b0110);
    check("par_ok_002", {31'd0, parity_err}, 32'd0);
    dut.mem[1] = dut.mem[1] ^ 4'b0001;
    read_at("par_rd_001_bad", 12'h001, 4'b1101);
    check("par_err_001", {31'd0, parity_err}, 32'd1);
    read_at("par_rd_002_again", 12'h002, 4'b0110);
    check("par_ok_002_again", {31'd0, parity_err}, 32'd0);
`endif

    // async reset from idle, then restart mid-clear and attempt writes while busy
    @(negedge clk);
    cs  = 1'b1;
    we  = 1'b0;
    rst = 1'b1;
    #1;
    check("async_busy", {31'd0, busy}, 32'd1);
    check("reset_bus_released", {28'd0, data}, 32'hF);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midclear_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst     = 1'b0;
    address = 12'h005;
    cs      = 1'b1;
    we      = 1'b1;
    tb_data = 4'b1111;
    tb_en   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) begin
        we    = 1'b0;
        tb_en = 1'b0;
      end
      if (n == 4090) begin
        we    = 1'b1;
        tb_en = 1'b1;
      end
      if (n == 4092) begin
        we    = 1'b0;
        tb_en = 1'b0;
      end
    end while (busy && n < 5000);
    check("restart_clear_cycles", n, 32'd4096);

    read_at("lockout_005", 12'h005, 4'b0000);
    read_at("recleared_000", 12'h000, 4'b0000);
    read_at("recleared_fff", 12'hFFF, 4'b0000);
    write_at(12'h005, 4'b1111, 1'b1);
    read_at("post_busy_005", 12'h005, 4'b1111);

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
